prog_fetch_unit: RTL and testbench

Parametrised, loadable program memory with its own program counter and fetch sequencer for the small register-transfer CPU. It replaces a fixed 16-entry hard-coded instruction ROM with a RAM that is loaded while idle. It fetches instructions at the PC and presents them to the decoder over a valid/ready handshake. It supports decoder-driven jumps, halt, and end-of-program wrap or stop.

---
 rtl/cpu_isa_pkg.sv | 49 ++++
 rtl/prog_mem.sv | 46 ++++
 rtl/prog_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_prog_fetch_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the small register-transfer CPU.
// Holds the instruction field widths, funct codes, register encodings,
// the fetch sequencer state type and an instruction-packing helper.
package cpu_isa_pkg;

  localparam int FUNCT_W     = 5;
  localparam int REG_FIELD_W = 3;
  localparam int INSTR_W     = FUNCT_W + 2 * REG_FIELD_W;

  // Funct codes
  localparam logic [FUNCT_W-1:0] NULLS   = 5'h00;
  localparam logic [FUNCT_W-1:0] ONES    = 5'h01;
  localparam logic [FUNCT_W-1:0] NO_F    = 5'h02;
  localparam logic [FUNCT_W-1:0] NOT_F   = 5'h03;
  localparam logic [FUNCT_W-1:0] XOR_F   = 5'h04;
  localparam logic [FUNCT_W-1:0] XNOR_F  = 5'h05;
  localparam logic [FUNCT_W-1:0] INCR_F  = 5'h06;
  localparam logic [FUNCT_W-1:0] DECR_F  = 5'h07;
  localparam logic [FUNCT_W-1:0] COMPL_F = 5'h08;
  localparam logic [FUNCT_W-1:0] ADD_F   = 5'h09;
  localparam logic [FUNCT_W-1:0] SUBTR_F = 5'h0A;
  localparam logic [FUNCT_W-1:0] MOVE_F  = 5'h1A;

  // Register encodings
  localparam logic [REG_FIELD_W-1:0] R0 = 3'd0;
  localparam logic [REG_FIELD_W-1:0] R1 = 3'd1;
  localparam logic [REG_FIELD_W-1:0] R2 = 3'd2;
  localparam logic [REG_FIELD_W-1:0] R3 = 3'd3;
  localparam logic [REG_FIELD_W-1:0] R4 = 3'd4;
  localparam logic [REG_FIELD_W-1:0] R5 = 3'd5;
  localparam logic [REG_FIELD_W-1:0] R6 = 3'd6;
  localparam logic [REG_FIELD_W-1:0] R7 = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } fetch_state_e;

  // Packs {funct, src, dst} into one instruction word.
  function automatic logic [INSTR_W-1:0] make_instr(
    input logic [FUNCT_W-1:0]     funct,
    input logic [REG_FIELD_W-1:0] src,
    input logic [REG_FIELD_W-1:0] dst
  );
    return {funct, src, dst};
  endfunction

endpackage

// File: rtl/prog_mem.sv
// Program memory: DEPTH x DATA_W single-port RAM, synchronous read.
// Ports:
//   clk_i    clock
//   rst_i    async active-high reset (clears the read register only)
//   we_i     write strobe
//   re_i     read strobe; read register holds its value when low
//   addr_i   shared read/write address
//   wdata_i  write data
//   rdata_o  registered read data, one cycle after re_i
module prog_mem #(
  parameter int    ADDR_W    = 4,
  parameter int    DATA_W    = 11,
  parameter string INIT_FILE = ""
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array is not reset so it maps onto block RAM; contents survive rst.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_fetch_unit.sv
// Loadable program memory with PC and fetch sequencer.
// Loads instructions while idle, then fetches from address 0 on start and
// presents each word to the decoder over a valid/ready handshake.
// Ports:
//   clk, rst               clock, async active-high reset
//   load_en/addr/data      program write port (IDLE only)
//   start                  begin at address 0 (IDLE only, loses to load_en)
//   halt_req               abort execution, return to IDLE
//   jump_en/jump_addr      redirect, taken only on accept
//   instr_ready            decoder accepts the presented instruction
//   instr_valid/data/pc    presented instruction and its address
//   pc                     program counter
//   busy                   sequencer not idle
//   done                   one-cycle end-of-program pulse (WRAP=0)
module prog_fetch_unit
  import cpu_isa_pkg::*;
#(
  parameter int    ADDR_W    = 4,
  parameter int    DATA_W    = 11,
  parameter int    WRAP      = 1,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic              halt_req,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              instr_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] PC_LAST = '1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              done_q, done_d;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;

  // The only writes happen in IDLE, so the port is steered to the load
  // address there and to the PC everywhere else.
  assign mem_addr = (state_q == IDLE) ? load_addr : pc_q;

  prog_mem #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .INIT_FILE(INIT_FILE)
  ) u_mem (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (mem_we),
    .re_i   (mem_re),
    .addr_i (mem_addr),
    .wdata_i(load_data),
    .rdata_o(instr_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      instr_pc_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    done_d     = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_en) begin
          mem_we = 1'b1;
        end else if (start) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (halt_req) begin
          state_d = IDLE;
        end else begin
          // Read register and instr_pc load together, so data and address
          // stay paired and frozen for the whole PRESENT phase.
          mem_re     = 1'b1;
          instr_pc_d = pc_q;
          state_d    = PRESENT;
        end
      end
      PRESENT: begin
        if (halt_req) begin
          state_d = IDLE;
        end else if (instr_ready) begin
          if (jump_en) begin
            pc_d    = jump_addr;
            state_d = FETCH;
          end else if (pc_q == PC_LAST) begin
            pc_d = '0;
            if (WRAP != 0) begin
              state_d = FETCH;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign instr_valid = (state_q == PRESENT);
  assign instr_pc    = instr_pc_q;
  assign pc          = pc_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_prog_fetch_unit.sv
module tb_prog_fetch_unit;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [10:0] load_data;
  logic        start;
  logic        halt_req;
  logic        jump_en;
  logic [3:0]  jump_addr;
  logic        instr_ready;

  logic        w_valid, s_valid;
  logic [10:0] w_data, s_data;
  logic [3:0]  w_ipc, s_ipc, w_pc, s_pc;
  logic        w_busy, s_busy, w_done, s_done;

  int checks;
  int errors;

  logic [10:0] prog [16];

  prog_fetch_unit #(.ADDR_W(4), .DATA_W(11), .WRAP(1), .INIT_FILE("")) u_wrap (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .halt_req(halt_req),
    .jump_en(jump_en), .jump_addr(jump_addr), .instr_ready(instr_ready),
    .instr_valid(w_valid), .instr_data(w_data), .instr_pc(w_ipc),
    .pc(w_pc), .busy(w_busy), .done(w_done)
  );

  prog_fetch_unit #(.ADDR_W(4), .DATA_W(11), .WRAP(0), .INIT_FILE("")) u_stop (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .halt_req(halt_req),
    .jump_en(jump_en), .jump_addr(jump_addr), .instr_ready(instr_ready),
    .instr_valid(s_valid), .instr_data(s_data), .instr_pc(s_ipc),
    .pc(s_pc), .busy(s_busy), .done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        rdy;
    logic        jen;
    logic [3:0]  ja;
    logic        v;
    logic [10:0] d;
    logic [3:0]  ipc;
    logic [3:0]  pc;
    logic        busy;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic st, input logic rdy, input logic jen,
                              input logic [3:0] ja, input logic v,
                              input logic [10:0] d, input logic [3:0] ipc,
                              input logic [3:0] pc, input logic busy);
    vec_t r;
    r.st = st; r.rdy = rdy; r.jen = jen; r.ja = ja; r.v = v;
    r.d = d; r.ipc = ipc; r.pc = pc; r.busy = busy;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; halt_req = 1'b0; jump_en = 1'b0; jump_addr = '0;
    instr_ready = 1'b0;

    for (int i = 0; i < 16; i++) prog[i] = 11'h100 + 11'(i);
    prog[0] = 11'h6A2;
    prog[1] = 11'h62B;

    // Reset state
    step(); step();
    chk("rst_valid", {31'd0, w_valid}, 32'd0);
    chk("rst_pc", {28'd0, w_pc}, 32'd0);
    chk("rst_ipc", {28'd0, w_ipc}, 32'd0);
    chk("rst_data", {21'd0, w_data}, 32'd0);
    chk("rst_busy", {31'd0, w_busy}, 32'd0);
    chk("rst_done", {31'd0, s_done}, 32'd0);
    rst = 1'b0;
    step();

    // Load the whole program into both instances
    for (int i = 0; i < 16; i++) begin
      load_en = 1'b1; load_addr = 4'(i); load_data = prog[i];
      step();
      chk("load_busy", {31'd0, w_busy}, 32'd0);
    end
    load_en = 1'b0;

    // Start, backpressure, normal advance, jump with/without accept
    tbl.push_back(mk(1, 0, 0, 4'h0, 0, 11'h000, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 0, 0, 4'h0, 1, 11'h6A2, 4'h0, 4'h0, 1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0, 4'h0, 1, 11'h6A2, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 0, 4'h0, 0, 11'h000, 4'h0, 4'h1, 1));
    tbl.push_back(mk(0, 1, 0, 4'h0, 1, 11'h62B, 4'h1, 4'h1, 1));
    tbl.push_back(mk(0, 1, 0, 4'h0, 0, 11'h000, 4'h0, 4'h2, 1));
    tbl.push_back(mk(0, 1, 0, 4'h0, 1, 11'h102, 4'h2, 4'h2, 1));
    tbl.push_back(mk(0, 1, 0, 4'h0, 0, 11'h000, 4'h0, 4'h3, 1));
    tbl.push_back(mk(0, 0, 1, 4'hA, 1, 11'h103, 4'h3, 4'h3, 1));
    tbl.push_back(mk(0, 0, 1, 4'hA, 1, 11'h103, 4'h3, 4'h3, 1));
    tbl.push_back(mk(0, 1, 1, 4'hA, 0, 11'h000, 4'h0, 4'hA, 1));
    tbl.push_back(mk(0, 1, 0, 4'h0, 1, 11'h10A, 4'hA, 4'hA, 1));

    foreach (tbl[k]) begin
      start = tbl[k].st; instr_ready = tbl[k].rdy;
      jump_en = tbl[k].jen; jump_addr = tbl[k].ja;
      step();
      chk($sformatf("v%0d_valid", k), {31'd0, w_valid}, {31'd0, tbl[k].v});
      chk($sformatf("v%0d_pc", k), {28'd0, w_pc}, {28'd0, tbl[k].pc});
      chk($sformatf("v%0d_busy", k), {31'd0, w_busy}, {31'd0, tbl[k].busy});
      if (tbl[k].v) begin
        chk($sformatf("v%0d_data", k), {21'd0, w_data}, {21'd0, tbl[k].d});
        chk($sformatf("v%0d_ipc", k), {28'd0, w_ipc}, {28'd0, tbl[k].ipc});
      end
    end
    start = 1'b0; jump_en = 1'b0; jump_addr = '0;

    // Run from address 10 to the end of memory with ready held high
    instr_ready = 1'b1;
    for (int a = 10; a < 16; a++) begin
      step();
      chk($sformatf("run%0d_pc", a), {28'd0, w_pc}, 32'((a + 1) % 16));
      chk($sformatf("run%0d_wvalid", a), {31'd0, w_valid}, 32'd0);
      chk($sformatf("run%0d_wdone", a), {31'd0, w_done}, 32'd0);
      if (a == 15) begin
        chk("stop_done", {31'd0, s_done}, 32'd1);
        chk("stop_busy", {31'd0, s_busy}, 32'd0);
        chk("stop_valid", {31'd0, s_valid}, 32'd0);
        chk("stop_pc", {28'd0, s_pc}, 32'd0);
        chk("wrap_busy", {31'd0, w_busy}, 32'd1);
      end else begin
        chk($sformatf("run%0d_sdone", a), {31'd0, s_done}, 32'd0);
      end
      if (a < 15) begin
        step();
        chk($sformatf("run%0d_ipc", a + 1), {28'd0, w_ipc}, 32'(a + 1));
        chk($sformatf("run%0d_data", a + 1), {21'd0, w_data}, {21'd0, prog[a + 1]});
      end
    end
    instr_ready = 1'b0;
    step();
    chk("wrap_ipc", {28'd0, w_ipc}, 32'd0);
    chk("wrap_data", {21'd0, w_data}, 32'h6A2);
    chk("wrap_done", {31'd0, w_done}, 32'd0);
    chk("stop_done_pulse", {31'd0, s_done}, 32'd0);
    chk("stop_idle", {31'd0, s_busy}, 32'd0);

    // Halt in PRESENT with ready high: no accept, pc stays 0
    halt_req = 1'b1; instr_ready = 1'b1;
    step();
    halt_req = 1'b0; instr_ready = 1'b0;
    chk("haltp_busy", {31'd0, w_busy}, 32'd0);
    chk("haltp_valid", {31'd0, w_valid}, 32'd0);
    chk("haltp_pc", {28'd0, w_pc}, 32'd0);

    // Halt in FETCH
    start = 1'b1;
    step();
    start = 1'b0;
    chk("haltf_fetch", {31'd0, w_busy}, 32'd1);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("haltf_busy", {31'd0, w_busy}, 32'd0);
    chk("haltf_valid", {31'd0, w_valid}, 32'd0);
    step();
    chk("haltf_valid2", {31'd0, w_valid}, 32'd0);

    // load_en and start while busy are ignored
    start = 1'b1;
    step();
    load_en = 1'b1; load_addr = 4'h1; load_data = 11'h7FF;
    step();
    chk("ldbusy_ipc", {28'd0, w_ipc}, 32'd0);
    step();
    load_en = 1'b0; start = 1'b0; instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    step();
    chk("ldbusy_ipc1", {28'd0, w_ipc}, 32'd1);
    chk("ldbusy_data", {21'd0, w_data}, 32'h62B);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;

    // start together with load_en stays idle
    load_en = 1'b1; load_addr = 4'h5; load_data = prog[5]; start = 1'b1;
    step();
    load_en = 1'b0; start = 1'b0;
    chk("startld_busy", {31'd0, w_busy}, 32'd0);
    chk("startld_sbusy", {31'd0, s_busy}, 32'd0);

    // Asynchronous reset while presenting address 1
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    step();
    chk("pre_rst_pc", {28'd0, w_pc}, 32'd1);
    chk("pre_rst_valid", {31'd0, w_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, w_valid}, 32'd0);
    chk("arst_pc", {28'd0, w_pc}, 32'd0);
    chk("arst_busy", {31'd0, w_busy}, 32'd0);
    chk("arst_ipc", {28'd0, w_ipc}, 32'd0);
    #1 rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("post_rst_data0", {21'd0, w_data}, 32'h6A2);
    chk("post_rst_valid", {31'd0, w_valid}, 32'd1);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    step();
    chk("post_rst_data1", {21'd0, w_data}, 32'h62B);
    chk("post_rst_ipc1", {28'd0, w_ipc}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
